// File: rtl/rom_fetch_ctrl.sv
// rtl/rom_fetch_ctrl.sv - ROM fetch bus master between the IF stage and the ROM slave
//
// Issues one word fetch at a time to the ROM. It drives the active-low CS_/As_
// strobes, waits for the registered Rdy_ handshake, and captures the block-RAM
// output one clock later. The fetched word is held with a valid/stall handshake.
//
// Optional feature macro: ROM_FETCH_TIMEOUT_EN
//   defined   -> ACCESS is aborted after TMO_CYC cycles without Rdy_, and err pulses
//   undefined -> ACCESS waits indefinitely, and err is tied low
//
// Ports
//   clk, reset          system clock; synchronous active-high reset
//   req, req_addr       fetch request and word address from the IF stage
//   req_ack             combinational accept strobe for the current cycle
//   flush               abort any in-flight or held fetch
//   stall               consumer not ready; hold insn/insn_valid
//   insn, insn_addr     fetched word and its address
//   insn_valid          insn holds valid data
//   busy, err           state != IDLE; one-cycle timeout abort pulse
//   CS_, As_, Addr      ROM strobes (active-low) and word address
//   RdData, Rdy_        ROM block-RAM output and active-low ready

module rom_fetch_ctrl #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 32,
  parameter int TMO_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ack,
  input  logic              flush,
  input  logic              stall,
  output logic [DATA_W-1:0] insn,
  output logic [ADDR_W-1:0] insn_addr,
  output logic              insn_valid,
  output logic              busy,
  output logic              err,
  output logic              CS_,
  output logic              As_,
  output logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] RdData,
  input  logic              Rdy_
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    READY   = 2'd3
  } state_t;

  state_t state, state_n;
  logic   accept;
  logic   timeout;

`ifdef ROM_FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);
  logic [TW-1:0] tmo_cnt;
`else
  logic unused_tmo;
  assign unused_tmo = (TMO_CYC == 0);
`endif

  // A held word is consumed in the same cycle that a new request is accepted.
  // Because of that, READY can chain straight into the next ACCESS.
  always_comb begin
    accept  = req && !flush && ((state == IDLE) || ((state == READY) && !stall));
    req_ack = accept;
    timeout = 1'b0;
`ifdef ROM_FETCH_TIMEOUT_EN
    timeout = (state == ACCESS) && Rdy_ && (tmo_cnt == TMO_LAST);
`endif
    state_n = state;
    if (flush) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) state_n = ACCESS;
        end
        ACCESS: begin
          if (!Rdy_)        state_n = CAPTURE;
          else if (timeout) state_n = IDLE;
        end
        CAPTURE: state_n = READY;
        READY: begin
          if (!stall) state_n = accept ? ACCESS : IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Every output is derived from the next state, so the strobes, busy and
  // insn_valid change on the same edge as the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      CS_        <= 1'b1;
      As_        <= 1'b1;
      Addr       <= '0;
      insn       <= '0;
      insn_addr  <= '0;
      insn_valid <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      CS_        <= (state_n != ACCESS);
      As_        <= (state_n != ACCESS);
      busy       <= (state_n != IDLE);
      insn_valid <= (state_n == READY);
      err        <= timeout && !flush;
      if (accept) Addr <= req_addr;
      // The BRAM output lags the address by one clock.
      // For that reason, the word is sampled in CAPTURE rather than on the Rdy_ edge.
      if ((state == CAPTURE) && !flush) begin
        insn      <= RdData;
        insn_addr <= Addr;
      end
    end
  end

`ifdef ROM_FETCH_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if ((state_n == ACCESS) && (state != ACCESS)) begin
      tmo_cnt <= '0;
    end else if (state == ACCESS) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`endif

endmodule
